// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding imem requester, stale-response
// dropping after redirects, one-entry skid buffer and the IF/ID register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic          stall_d,
  input  logic          flush_d,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          valid_d,
  output logic [31:0]   instr_d,
  output logic [31:0]   pc_d,
  output logic [31:0]   pc_plus4_d,
  output logic [6:0]    opcode_d,
  output logic [2:0]    funct3_d,
  output logic [6:0]    funct7_d
);

  localparam logic [1:0]  S_REQ  = 2'd0;
  localparam logic [1:0]  S_WAIT = 2'd1;
  localparam logic [1:0]  S_DROP = 2'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        accept;
  logic        resp_live;
  logic        kill;
  logic [31:0] target_pc;
  logic [31:0] load_pc;
  logic        unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];
  assign target_pc      = {redirect_pc[31:2], 2'b00};

  // Request outputs depend on state registers only, never on any input.
  assign imem.imem_req  = (state == S_REQ) && !buf_valid;
  assign imem.imem_addr = fetch_pc;

  assign accept    = imem.imem_req && imem.imem_ready;
  // A response is usable only in WAIT and only if no redirect lands with it.
  assign resp_live = imem.imem_rvalid && (state == S_WAIT) && !redirect;
  assign kill      = redirect || flush_d;
  assign load_pc   = buf_valid ? buf_pc : req_pc;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (accept) state_nxt = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (imem.imem_rvalid) state_nxt = S_REQ;
        else if (redirect)    state_nxt = S_DROP;
      end
      S_DROP:  if (imem.imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_pc   <= {RESET_PC[31:2], 2'b00};
    end else begin
      state <= state_nxt;
      if (redirect)    fetch_pc <= target_pc;
      else if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (accept) req_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
    end else if (kill) begin
      buf_valid <= 1'b0;
    end else if (stall_d) begin
      if (resp_live) buf_valid <= 1'b1;
    end else begin
      buf_valid <= 1'b0;
    end
  end

  // NOTE: skid payload has no reset; it is only ever read while buf_valid is set.
  always_ff @(posedge clk) begin
    if (!kill && stall_d && resp_live) begin
      buf_instr <= imem.imem_rdata;
      buf_pc    <= req_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d    <= 1'b0;
      instr_d    <= NOP;
      pc_d       <= 32'h0000_0000;
      pc_plus4_d <= 32'h0000_0004;
    end else if (kill) begin
      valid_d <= 1'b0;
      instr_d <= NOP;
    end else if (!stall_d) begin
      if (buf_valid || resp_live) begin
        valid_d    <= 1'b1;
        instr_d    <= buf_valid ? buf_instr : imem.imem_rdata;
        pc_d       <= load_pc;
        pc_plus4_d <= load_pc + 32'd4;
      end else begin
        valid_d <= 1'b0;
        instr_d <= NOP;
      end
    end
  end

  assign opcode_d = instr_d[6:0];
  assign funct3_d = instr_d[14:12];
  assign funct7_d = instr_d[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by random
// stall/flush/redirect/ready/latency traffic against a program-order model.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_if imem ();
  logic        stall_d, flush_d, redirect;
  logic [31:0] redirect_pc;
  logic        valid_d;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic [6:0]  opcode_d, funct7_d;
  logic [2:0]  funct3_d;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid_d     (valid_d),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .opcode_d    (opcode_d),
    .funct3_d    (funct3_d),
    .funct7_d    (funct7_d)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Model: next address fetch must request, next pc decode must see, memory side.
  logic [31:0] m_fpc, m_exp, m_paddr;
  bit          m_pending, m_resync;
  int          m_cnt, m_slack;

  bit          g_stall, g_flush, g_redir, g_ready, g_force_rv;
  logic [31:0] g_rpc, g_force_data;
  int          g_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    m_fpc = RESET_PC; m_exp = RESET_PC;
    m_pending = 0; m_resync = 0; m_slack = 0; m_cnt = 0;
  endtask

  task automatic set_in(input bit s, input bit f, input bit r, input logic [31:0] rpc,
                        input bit rdy, input int lat);
    g_stall = s; g_flush = f; g_redir = r; g_rpc = rpc; g_ready = rdy; g_lat = lat;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step();
    logic [31:0] w;
    logic        rv;
    logic [31:0] rd;
    logic        acc;
    if (imem.imem_req) check("req_addr", imem.imem_addr, m_fpc);
    if (m_pending) check("one_outstanding", 32'(imem.imem_req), 32'd0);
    if (!valid_d) check("bubble_nop", instr_d, NOP);
    else begin
      w = mem_word(pc_d);
      check("instr", instr_d, w);
      check("pc_plus4", pc_plus4_d, pc_d + 32'd4);
      check("opcode", 32'(opcode_d), 32'(w[6:0]));
      check("funct3", 32'(funct3_d), 32'(w[14:12]));
      check("funct7", 32'(funct7_d), 32'(w[31:25]));
    end

    rv = 1'b0;
    rd = $urandom;
    if (g_force_rv) begin
      rv = 1'b1; rd = g_force_data;
    end else if (m_pending) begin
      if (m_cnt == 0) begin rv = 1'b1; rd = mem_word(m_paddr); end
      else m_cnt = m_cnt - 1;
    end
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rd;
    imem.imem_ready  = g_ready;
    stall_d     = g_stall;
    flush_d     = g_flush;
    redirect    = g_redir;
    redirect_pc = g_rpc;
    acc = imem.imem_req && g_ready;

    if (valid_d && !g_stall && !g_redir && !g_flush) begin
      if (m_resync) begin
        check("resync_window", 32'((pc_d - m_exp) <= 32'(m_slack * 4)), 32'd1);
        m_resync = 0; m_slack = 0;
      end else begin
        check("order", pc_d, m_exp);
      end
      m_exp = pc_d + 32'd4;
    end
    if (g_redir) begin
      m_fpc = align(g_rpc); m_exp = align(g_rpc); m_resync = 0; m_slack = 0;
    end else begin
      if (acc) m_fpc = m_fpc + 32'd4;
      if (g_flush) begin m_resync = 1; m_slack = m_slack + 2; end
    end
    if (rv) m_pending = 0;
    if (acc) begin m_pending = 1; m_paddr = imem.imem_addr; m_cnt = g_lat; end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    stall_d = 0; flush_d = 0; redirect = 0; redirect_pc = 0;
    imem.imem_ready = 0; imem.imem_rvalid = 1; imem.imem_rdata = 32'hDEAD_BEEF;
    g_force_rv = 0; g_force_data = 0;
    set_in(0, 0, 0, 0, 1, 0);
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(valid_d), 32'd0);
    check("rst_instr", instr_d, NOP);
    check("rst_pc", pc_d, 32'h0);
    check("rst_pc4", pc_plus4_d, 32'h4);
    imem.imem_rvalid = 0;
    rst_n = 1;
    model_reset();
    check("first_req", 32'(imem.imem_req), 32'd1);
    check("first_addr", imem.imem_addr, RESET_PC);

    // Sequential fetch with single-cycle memory latency.
    step();
    check("wait_no_req", 32'(imem.imem_req), 32'd0);
    step();
    check("033_valid", 32'(valid_d), 32'd1);
    check("033_instr", instr_d, 32'h0050_0093);
    check("033_pc", pc_d, 32'h0);
    check("033_opcode", 32'(opcode_d), 32'h13);
    check("033_next_addr", imem.imem_addr, 32'h4);

    // Response for 0x4 lands during a stall and goes to the skid buffer.
    set_in(1, 0, 0, 0, 1, 0); step(); step();
    check("034_hold_pc", pc_d, 32'h0);
    check("034_hold_valid", 32'(valid_d), 32'd1);
    check("034_no_req", 32'(imem.imem_req), 32'd0);
    set_in(0, 0, 0, 0, 1, 1); step();
    check("034_drain_pc", pc_d, 32'h4);
    check("034_resume_req", 32'(imem.imem_req), 32'd1);
    check("034_resume_addr", imem.imem_addr, 32'h8);

    // Redirect while waiting for 0x8; the late response must be dropped.
    step();
    set_in(0, 0, 1, 32'h103, 1, 0); step();
    check("035_valid", 32'(valid_d), 32'd0);
    check("035_drop_no_req", 32'(imem.imem_req), 32'd0);
    set_in(0, 0, 0, 0, 1, 0); step();
    check("035_stale_dropped", 32'(valid_d), 32'd0);
    check("035_req", 32'(imem.imem_req), 32'd1);
    check("035_addr", imem.imem_addr, 32'h100);
    step(); step();
    check("035_target_pc", pc_d, 32'h100);

    // Redirect coinciding with rvalid in WAIT.
    step();
    set_in(0, 0, 1, 32'h200, 1, 0); step();
    check("036_valid", 32'(valid_d), 32'd0);
    check("036_req_now", 32'(imem.imem_req), 32'd1);
    check("036_addr", imem.imem_addr, 32'h200);
    set_in(0, 0, 0, 0, 1, 0); step(); step();
    check("036_target_pc", pc_d, 32'h200);

    // Address wrap at the top of memory.
    set_in(0, 0, 1, 32'hFFFF_FFFC, 0, 0); step();
    check("037_addr_top", imem.imem_addr, 32'hFFFF_FFFC);
    set_in(0, 0, 0, 0, 1, 0); step();
    check("037_addr_wrap", imem.imem_addr, 32'h0);
    step();
    check("037_pc", pc_d, 32'hFFFF_FFFC);
    check("037_pc4_wrap", pc_plus4_d, 32'h0);

    // Reset in the middle of WAIT; rvalid during and after reset is ignored.
    set_in(0, 0, 0, 0, 1, 2); step();
    rst_n = 0;
    imem.imem_rvalid = 1; imem.imem_rdata = 32'hBAD0_BAD0;
    #1;
    check("038_async_valid", 32'(valid_d), 32'd0);
    @(posedge clk); @(negedge clk);
    imem.imem_rvalid = 0;
    rst_n = 1;
    model_reset();
    g_force_rv = 1; g_force_data = 32'hBAD1_BAD1;
    set_in(0, 0, 0, 0, 0, 0); step();
    g_force_rv = 0;
    check("038_late_ignored", 32'(valid_d), 32'd0);
    check("038_req", 32'(imem.imem_req), 32'd1);
    check("038_addr", imem.imem_addr, RESET_PC);
    set_in(0, 0, 0, 0, 1, 0); step(); step();
    check("038_first_valid", 32'(valid_d), 32'd1);
    check("038_first_instr", instr_d, 32'h0050_0093);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else rpc = $urandom & 32'h0000_3FFF;
      set_in($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 4, rpc, $urandom_range(0, 99) < 70,
             int'($urandom_range(0, 3)));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
